// File: rtl/serial_sched_pkg.sv
// Shared types for the serial transmit scheduler: frame-sequencer states and id-width helper.
package serial_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ID,
        LEN,
        DATA,
        PAR,
        GAP
    } schedState_e;

    function automatic int calcIdW(input int numReq);
        return (numReq > 1) ? $clog2(numReq) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester-side bus of the serial transmit scheduler: request/length/data in, grant/done/serial line out.
interface serial_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  len;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      ser_out;
    logic                      bit_strobe;
    logic                      busy;

    modport master (
        output req, len, data,
        input  grant, done, ser_out, bit_strobe, busy
    );

    modport slave (
        input  req, len, data,
        output grant, done, ser_out, bit_strobe, busy
    );
endinterface

// File: rtl/serial_tx_scheduler_bit_timer.sv
// Serial bit timer: counts BIT_DIV clocks per bit, flags the last cycle and the mid-bit strobe cycle.
module serial_bit_timer #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_bitEnd,
    output logic o_mid
);
    localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign o_bitEnd = i_en && (r_cnt == CNT_W'(BIT_DIV - 1));
    assign o_mid    = i_en && (r_cnt == CNT_W'(BIT_DIV / 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear || !i_en || o_bitEnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler serialising one frame (start, id, length, data) per grant onto a shared link.
// Optional even-parity bit after DATA when SERIAL_SCHED_PARITY_EN is defined.
module serial_tx_scheduler
    import serial_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int DATA_W  = 16,
    parameter int BIT_DIV = 4
) (
    input logic                  clk,
    input logic                  rst,
    serial_tx_scheduler_if.slave bus
);
    localparam int ID_W  = calcIdW(NUM_REQ);
    localparam int IDX_W = (ID_W > LEN_W) ? ID_W : LEN_W;

    schedState_e        r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_busy;
    logic               r_serOut;
    logic               r_par;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_idSh;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_lenSh;
    logic [DATA_W-1:0]  r_dataSh;
    logic [IDX_W-1:0]   r_left;

    logic                 w_bitEnd;
    logic                 w_mid;
    logic                 w_found;
    logic                 w_grantNow;
    logic [ID_W-1:0]      w_pick;
    logic [ID_W-1:0]      w_base;
    logic [ID_W-1:0]      w_nextPtr;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [LEN_W-1:0]     w_lenArr  [NUM_REQ];
    logic [DATA_W-1:0]    w_dataArr [NUM_REQ];
    schedState_e          w_tailState;
    logic                 w_tailBit;

    serial_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_grantNow),
        .i_en     (r_state != IDLE),
        .o_bitEnd (w_bitEnd),
        .o_mid    (w_mid)
    );

    assign w_nextPtr = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);
    // In the final GAP cycle the pointer has not moved yet, so arbitrate from owner+1 directly.
    assign w_base    = (r_state == GAP) ? w_nextPtr : r_ptr;
    assign w_rot     = {bus.req, bus.req} >> w_base;

    always_comb begin
        int sum;
        sum     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                sum     = int'(w_base) + k;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                w_pick  = ID_W'(sum);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_lenArr[i]  = bus.len[i*LEN_W +: LEN_W];
            w_dataArr[i] = bus.data[i*DATA_W +: DATA_W];
        end
    end

    assign w_grantNow = w_found && ((r_state == IDLE) || ((r_state == GAP) && w_bitEnd));

`ifdef SERIAL_SCHED_PARITY_EN
    // Parity bit makes the count of ones over ID, LEN and DATA even.
    assign w_tailState = PAR;
    assign w_tailBit   = r_par;
`else
    assign w_tailState = GAP;
    assign w_tailBit   = 1'b1;
`endif

    // Payload is left-aligned at grant so DATA always shifts out of the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_serOut <= 1'b1;
            r_par    <= 1'b0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_idSh   <= '0;
            r_len    <= '0;
            r_lenSh  <= '0;
            r_dataSh <= '0;
            r_left   <= '0;
        end else begin
            if (w_grantNow) begin
                r_state  <= START;
                r_grant  <= NUM_REQ'(1) << w_pick;
                r_busy   <= 1'b1;
                r_serOut <= 1'b0;
                r_par    <= 1'b0;
                r_owner  <= w_pick;
                r_idSh   <= w_pick;
                r_len    <= w_lenArr[w_pick];
                r_lenSh  <= w_lenArr[w_pick];
                r_dataSh <= w_dataArr[w_pick] << (DATA_W - int'(w_lenArr[w_pick]));
            end else if (w_bitEnd) begin
                case (r_state)
                    START: begin
                        r_state  <= ID;
                        r_serOut <= r_idSh[ID_W-1];
                        r_par    <= r_par ^ r_idSh[ID_W-1];
                        r_idSh   <= r_idSh << 1;
                        r_left   <= IDX_W'(ID_W - 1);
                    end
                    ID: begin
                        if (r_left == '0) begin
                            r_state  <= LEN;
                            r_serOut <= r_lenSh[LEN_W-1];
                            r_par    <= r_par ^ r_lenSh[LEN_W-1];
                            r_lenSh  <= r_lenSh << 1;
                            r_left   <= IDX_W'(LEN_W - 1);
                        end else begin
                            r_serOut <= r_idSh[ID_W-1];
                            r_par    <= r_par ^ r_idSh[ID_W-1];
                            r_idSh   <= r_idSh << 1;
                            r_left   <= r_left - IDX_W'(1);
                        end
                    end
                    LEN: begin
                        if (r_left != '0) begin
                            r_serOut <= r_lenSh[LEN_W-1];
                            r_par    <= r_par ^ r_lenSh[LEN_W-1];
                            r_lenSh  <= r_lenSh << 1;
                            r_left   <= r_left - IDX_W'(1);
                        end else if (r_len == '0) begin
                            r_state  <= w_tailState;
                            r_serOut <= w_tailBit;
                        end else begin
                            r_state  <= DATA;
                            r_serOut <= r_dataSh[DATA_W-1];
                            r_par    <= r_par ^ r_dataSh[DATA_W-1];
                            r_dataSh <= r_dataSh << 1;
                            r_left   <= IDX_W'(r_len) - IDX_W'(1);
                        end
                    end
                    DATA: begin
                        if (r_left == '0) begin
                            r_state  <= w_tailState;
                            r_serOut <= w_tailBit;
                        end else begin
                            r_serOut <= r_dataSh[DATA_W-1];
                            r_par    <= r_par ^ r_dataSh[DATA_W-1];
                            r_dataSh <= r_dataSh << 1;
                            r_left   <= r_left - IDX_W'(1);
                        end
                    end
                    PAR: begin
                        r_state  <= GAP;
                        r_serOut <= 1'b1;
                    end
                    GAP: begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_serOut <= 1'b1;
                    end
                endcase
            end
            if ((r_state == GAP) && w_bitEnd) r_ptr <= w_nextPtr;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.busy       = r_busy;
    assign bus.ser_out    = r_serOut;
    assign bus.bit_strobe = w_mid && (r_state != GAP);
    assign bus.done       = ((r_state == GAP) && w_bitEnd) ? r_grant : '0;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench for serial_tx_scheduler: directed vector table, corner sequences, randomized frames
// checked against a bit-list frame model and a round-robin reference.
module tb_serial_tx_scheduler;
    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 16;
    localparam int BIT_DIV = 4;
    localparam int ID_W    = 2;
`ifdef SERIAL_SCHED_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_scheduler_if #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    serial_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .DATA_W  (DATA_W),
        .BIT_DIV (BIT_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NUM_REQ-1:0] req;
        int                 lenVal;
        logic [DATA_W-1:0]  dataVal;
        logic [NUM_REQ-1:0] expGrant;
        int                 expStrobes;
    } vec_t;

    vec_t vecs [5];
    int   nCompared = 0;
    int   nMismatch = 0;
    int   mPtr      = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] l,
                                 input logic [NUM_REQ*DATA_W-1:0] d);
        bus.req  = r;
        bus.len  = l;
        bus.data = d;
    endtask

    function automatic int rrPick(input logic [NUM_REQ-1:0] r, input int p);
        int idx;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (p + k) % NUM_REQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Frame as an ordered bit list: start 0, id MSB first, length MSB first, data[len-1..0], optional parity.
    function automatic void buildFrame(input int id, input int l, input logic [DATA_W-1:0] d,
                                       output logic [63:0] bits, output int n);
        logic p;
        bits = '1;
        n    = 0;
        p    = 1'b0;
        bits[n[5:0]] = 1'b0;
        n++;
        for (int i = ID_W - 1; i >= 0; i--) begin
            bits[n[5:0]] = ((id >> i) & 1) != 0;
            p = p ^ bits[n[5:0]];
            n++;
        end
        for (int i = LEN_W - 1; i >= 0; i--) begin
            bits[n[5:0]] = ((l >> i) & 1) != 0;
            p = p ^ bits[n[5:0]];
            n++;
        end
        for (int i = l - 1; i >= 0; i--) begin
            bits[n[5:0]] = ((d >> i) & 16'd1) != 0;
            p = p ^ bits[n[5:0]];
            n++;
        end
        if (PAR_BITS == 1) begin
            bits[n[5:0]] = p;
            n++;
        end
    endfunction

    // Starts on the first granted cycle, returns on the negedge of the last GAP cycle.
    task automatic runFrame(input int owner, input int l, input logic [DATA_W-1:0] d,
                            input bit scramble, input string tag, input int expStrobes);
        logic [63:0]        bits;
        logic [NUM_REQ-1:0] oneHot;
        int n, total, serErr, strbCnt, strbErr, doneErr, doneSeen, grantErr, b, pos;
        logic expSer;
        buildFrame(owner, l, d, bits, n);
        total    = (n + 1) * BIT_DIV;
        oneHot   = NUM_REQ'(1) << owner;
        serErr   = 0;
        strbCnt  = 0;
        strbErr  = 0;
        doneErr  = 0;
        doneSeen = 0;
        grantErr = 0;
        for (int c = 0; c < total; c++) begin
            b      = c / BIT_DIV;
            pos    = c % BIT_DIV;
            expSer = (b < n) ? bits[b[5:0]] : 1'b1;
            if (bus.ser_out !== expSer) serErr++;
            if (bus.bit_strobe === 1'b1) begin
                strbCnt++;
                if (pos != BIT_DIV / 2 || b >= n) strbErr++;
            end else if (bus.bit_strobe !== 1'b0) begin
                strbErr++;
            end
            if (c == total - 1) begin
                if (bus.done === oneHot) doneSeen = 1;
                else doneErr++;
            end else if (bus.done !== '0) begin
                doneErr++;
            end
            if (bus.grant !== oneHot || bus.busy !== 1'b1) grantErr++;
            if (scramble && c == total - 2 * BIT_DIV) begin
                bus.req  = '0;
                bus.data = ~bus.data;
                bus.len  = ~bus.len;
            end
            if (c < total - 1) @(negedge clk);
        end
        checkOutput({tag, "_serial_bits_wrong"}, serErr, 0);
        checkOutput({tag, "_strobe_count"}, strbCnt, (expStrobes < 0) ? n : expStrobes);
        checkOutput({tag, "_strobe_misplaced"}, strbErr, 0);
        checkOutput({tag, "_done_pulse"}, {doneSeen[0], doneErr[31:0]}, {1'b1, 32'd0});
        checkOutput({tag, "_grant_held"}, grantErr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got time limit expiry, expected summary before it");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0]        reqV;
        logic [NUM_REQ*LEN_W-1:0]  lenV;
        logic [NUM_REQ*DATA_W-1:0] dataV;
        int owner, lOwn;
        int b2b [5];

        vecs[0] = '{4'b0001, 3,  16'h0005, 4'b0001, 10 + PAR_BITS};
        vecs[1] = '{4'b0100, 0,  16'hFFFF, 4'b0100, 7 + PAR_BITS};
        vecs[2] = '{4'b0101, 1,  16'h0001, 4'b0001, 8 + PAR_BITS};
        vecs[3] = '{4'b1111, 15, 16'hA5C3, 4'b0010, 22 + PAR_BITS};
        vecs[4] = '{4'b1001, 2,  16'h0002, 4'b1000, 9 + PAR_BITS};
        b2b     = '{0, 1, 2, 3, 0};

        rst = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (3) @(negedge clk);
        checkOutput("reset_grant", bus.grant, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_ser_out", bus.ser_out, 1);
        checkOutput("reset_strobe_done", {bus.bit_strobe, bus.done}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].req, {NUM_REQ{LEN_W'(vecs[v].lenVal)}}, {NUM_REQ{vecs[v].dataVal}});
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant_latency", v), bus.grant, vecs[v].expGrant);
            owner = $clog2(vecs[v].expGrant);
            runFrame(owner, vecs[v].lenVal, vecs[v].dataVal, 1'b0, $sformatf("vec%0d", v), vecs[v].expStrobes);
            mPtr = (owner + 1) % NUM_REQ;
            applyStimulus('0, bus.len, bus.data);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_idle_after", v), {bus.grant, bus.busy, bus.ser_out}, {4'b0000, 1'b0, 1'b1});
        end

        // req=1111 held: strict rotation with frames back to back.
        applyStimulus(4'b1111, {NUM_REQ{4'd0}}, '0);
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            checkOutput($sformatf("b2b%0d_grant", f), bus.grant, NUM_REQ'(1) << b2b[f]);
            runFrame(b2b[f], 0, '0, 1'b0, $sformatf("b2b%0d", f), 7 + PAR_BITS);
        end
        applyStimulus('0, '0, '0);
        @(negedge clk);

        // Reset while DATA is being sent, then recover with a new requester.
        applyStimulus(4'b0001, {NUM_REQ{4'd8}}, {NUM_REQ{16'h00B7}});
        @(negedge clk);
        checkOutput("abort_grant", bus.grant, 4'b0001);
        repeat (36) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_ser_out", bus.ser_out, 1);
        checkOutput("abort_grant_busy", {bus.grant, bus.busy}, 0);
        checkOutput("abort_strobe_done", {bus.bit_strobe, bus.done}, 0);
        repeat (2) @(negedge clk);
        applyStimulus(4'b0010, {NUM_REQ{4'd3}}, {NUM_REQ{16'h0005}});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("recover_grant", bus.grant, 4'b0010);
        runFrame(1, 3, 16'h0005, 1'b1, "recover", 10 + PAR_BITS);
        mPtr = 2;

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                lenV[i*LEN_W +: LEN_W]    = LEN_W'($urandom_range(0, 15));
                dataV[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
            reqV = NUM_REQ'($urandom_range(0, 15));
            applyStimulus(reqV, lenV, dataV);
            if (reqV == '0) begin
                @(negedge clk);
                checkOutput($sformatf("rand%0d_idle", f), {bus.grant, bus.busy}, 0);
                reqV = NUM_REQ'($urandom_range(1, 15));
                applyStimulus(reqV, lenV, dataV);
            end
            @(negedge clk);
            owner = rrPick(reqV, mPtr);
            checkOutput($sformatf("rand%0d_grant", f), bus.grant, NUM_REQ'(1) << owner);
            lOwn = int'(lenV[owner*LEN_W +: LEN_W]);
            runFrame(owner, lOwn, dataV[owner*DATA_W +: DATA_W], 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", f), -1);
            mPtr = (owner + 1) % NUM_REQ;
        end
        applyStimulus('0, '0, '0);
        @(negedge clk);
        checkOutput("final_idle", {bus.grant, bus.busy, bus.ser_out}, {4'b0000, 1'b0, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
